// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the router packet transmitter.
//   tx_state_e   : transmitter FSM states
//   ADDR_INVALID : the one destination code the router does not implement
//   LEN_MAX      : largest payload length; also the last buffer index
//   hdr_pack()   : builds the header byte {len, addr}
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY
  } tx_state_e;

  localparam logic [1:0] ADDR_INVALID = 2'b11;
  localparam logic [5:0] LEN_MAX      = 6'd63;

  function automatic logic [7:0] hdr_pack(input logic [5:0] len, input logic [1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// router_tx_buf: 64x8 payload buffer for router_pkt_tx.
//   clock    in  : rising-edge clock
//   i_we     in  : write enable
//   i_waddr  in  : write index
//   i_wdata  in  : write byte
//   i_raddr  in  : read index (combinational read)
//   o_rdata  out : byte at i_raddr
module router_tx_buf
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       i_we,
  input  logic [5:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [5:0] i_raddr,
  output logic [7:0] o_rdata
);

  logic [7:0] r_mem [0:LEN_MAX];

  // NOTE: storage is deliberately not reset; every byte is written in FILL
  // before it can be read, so a reset would only cost a clear network.
  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet source for the router input port.
// Accepts a command plus payload into a local buffer, then sends header,
// payload and parity on pkt_valid/data_out while honouring busy.
//   BUSY_TIMEOUT       : consecutive busy edges before the packet is aborted
//   clock, resetn      : clock, synchronous active-low reset
//   i_cmd_*            : command (addr, len, corrupt) with valid; o_cmd_ready
//   i_pl_valid/i_pl_data, o_pl_ready : payload byte load
//   i_busy             : router back-pressure
//   o_pkt_valid, o_data_out : router link
//   o_done, o_err_cmd, o_err_timeout : single-cycle status pulses
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       i_cmd_valid,
  input  logic [1:0] i_cmd_addr,
  input  logic [5:0] i_cmd_len,
  input  logic       i_cmd_corrupt,
  output logic       o_cmd_ready,
  input  logic       i_pl_valid,
  input  logic [7:0] i_pl_data,
  output logic       o_pl_ready,
  input  logic       i_busy,
  output logic       o_pkt_valid,
  output logic [7:0] o_data_out,
  output logic       o_done,
  output logic       o_err_cmd,
  output logic       o_err_timeout
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(BUSY_TIMEOUT);

  tx_state_e        r_state,     w_nxt_state;
  logic [1:0]       r_addr,      w_nxt_addr;
  logic [5:0]       r_len,       w_nxt_len;
  logic             r_corrupt,   w_nxt_corrupt;
  logic [5:0]       r_wptr,      w_nxt_wptr;
  logic [5:0]       r_rptr,      w_nxt_rptr;
  logic [7:0]       r_parity,    w_nxt_parity;
  logic [CNT_W-1:0] r_cnt,       w_nxt_cnt;
  logic             r_pkt_valid, w_nxt_pkt_valid;
  logic [7:0]       r_data_out,  w_nxt_data_out;
  logic             r_done,      w_nxt_done;
  logic             r_err_cmd,   w_nxt_err_cmd;
  logic             r_err_to,    w_nxt_err_to;
  logic             r_cmd_ready;
  logic             r_pl_ready;

  logic             w_buf_we;
  logic [5:0]       w_rd_addr;
  logic [7:0]       w_rd_data;
  logic             w_in_tx;
  logic [7:0]       w_par_acc;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_buf_we  = (r_state == ST_FILL) && i_pl_valid && r_pl_ready;
  assign w_in_tx   = (r_state == ST_HEADER) || (r_state == ST_PAYLOAD) ||
                     (r_state == ST_PARITY);
  // Read index is the pointer value after the pending accept, so the byte
  // for the next bus cycle can be loaded straight into r_data_out.
  assign w_rd_addr = (r_state == ST_PAYLOAD) ? r_rptr + 6'd1 : 6'd0;
  assign w_par_acc = r_parity ^ r_data_out;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  router_tx_buf u_buf (
    .clock   (clock),
    .i_we    (w_buf_we),
    .i_waddr (r_wptr),
    .i_wdata (i_pl_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_addr      = r_addr;
    w_nxt_len       = r_len;
    w_nxt_corrupt   = r_corrupt;
    w_nxt_wptr      = r_wptr;
    w_nxt_rptr      = r_rptr;
    w_nxt_parity    = r_parity;
    w_nxt_cnt       = r_cnt;
    w_nxt_pkt_valid = r_pkt_valid;
    w_nxt_data_out  = r_data_out;
    w_nxt_done      = 1'b0;
    w_nxt_err_cmd   = 1'b0;
    w_nxt_err_to    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid && r_cmd_ready) begin
          if ((i_cmd_addr == ADDR_INVALID) || (i_cmd_len == 6'd0)) begin
            w_nxt_err_cmd = 1'b1;
          end else begin
            w_nxt_addr    = i_cmd_addr;
            w_nxt_len     = i_cmd_len;
            w_nxt_corrupt = i_cmd_corrupt;
            w_nxt_wptr    = 6'd0;
            w_nxt_state   = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        if (w_buf_we) begin
          w_nxt_wptr = r_wptr + 6'd1;
          if (r_wptr == r_len - 6'd1) begin
            w_nxt_state     = ST_HEADER;
            w_nxt_pkt_valid = 1'b1;
            w_nxt_data_out  = hdr_pack(r_len, r_addr);
            w_nxt_cnt       = '0;
          end
        end
      end

      ST_HEADER: begin
        if (!i_busy) begin
          // The header is on the bus now, so it seeds the parity.
          w_nxt_parity   = r_data_out;
          w_nxt_rptr     = w_rd_addr;
          w_nxt_data_out = w_rd_data;
          w_nxt_state    = ST_PAYLOAD;
        end
      end

      ST_PAYLOAD: begin
        if (!i_busy) begin
          w_nxt_parity = w_par_acc;
          w_nxt_rptr   = w_rd_addr;
          if (r_rptr == r_len - 6'd1) begin
            w_nxt_state     = ST_PARITY;
            w_nxt_pkt_valid = 1'b0;
            w_nxt_data_out  = w_par_acc ^ {8{r_corrupt}};
          end else begin
            w_nxt_data_out = w_rd_data;
          end
        end
      end

      ST_PARITY: begin
        if (!i_busy) begin
          w_nxt_done     = 1'b1;
          w_nxt_data_out = 8'h00;
          w_nxt_state    = ST_IDLE;
        end
      end

      default: w_nxt_state = ST_IDLE;
    endcase

    // Busy watchdog shared by all bus states; a stall holds the bus stable.
    if (w_in_tx) begin
      if (!i_busy) begin
        w_nxt_cnt = '0;
      end else if (w_cnt_inc == CNT_LIMIT) begin
        w_nxt_err_to    = 1'b1;
        w_nxt_pkt_valid = 1'b0;
        w_nxt_data_out  = 8'h00;
        w_nxt_cnt       = '0;
        w_nxt_state     = ST_IDLE;
      end else begin
        w_nxt_cnt = w_cnt_inc;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_addr      <= 2'd0;
      r_len       <= 6'd0;
      r_corrupt   <= 1'b0;
      r_wptr      <= 6'd0;
      r_rptr      <= 6'd0;
      r_parity    <= 8'h00;
      r_cnt       <= '0;
      r_pkt_valid <= 1'b0;
      r_data_out  <= 8'h00;
      r_done      <= 1'b0;
      r_err_cmd   <= 1'b0;
      r_err_to    <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_pl_ready  <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_addr      <= w_nxt_addr;
      r_len       <= w_nxt_len;
      r_corrupt   <= w_nxt_corrupt;
      r_wptr      <= w_nxt_wptr;
      r_rptr      <= w_nxt_rptr;
      r_parity    <= w_nxt_parity;
      r_cnt       <= w_nxt_cnt;
      r_pkt_valid <= w_nxt_pkt_valid;
      r_data_out  <= w_nxt_data_out;
      r_done      <= w_nxt_done;
      r_err_cmd   <= w_nxt_err_cmd;
      r_err_to    <= w_nxt_err_to;
      r_cmd_ready <= (w_nxt_state == ST_IDLE);
      r_pl_ready  <= (w_nxt_state == ST_FILL);
    end
  end

  assign o_cmd_ready   = r_cmd_ready;
  assign o_pl_ready    = r_pl_ready;
  assign o_pkt_valid   = r_pkt_valid;
  assign o_data_out    = r_data_out;
  assign o_done        = r_done;
  assign o_err_cmd     = r_err_cmd;
  assign o_err_timeout = r_err_to;

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: directed self-checking bench for router_pkt_tx.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       resetn;
  logic       i_cmd_valid;
  logic [1:0] i_cmd_addr;
  logic [5:0] i_cmd_len;
  logic       i_cmd_corrupt;
  logic       o_cmd_ready;
  logic       i_pl_valid;
  logic [7:0] i_pl_data;
  logic       o_pl_ready;
  logic       i_busy;
  logic       o_pkt_valid;
  logic [7:0] o_data_out;
  logic       o_done;
  logic       o_err_cmd;
  logic       o_err_timeout;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] pl_buf [0:62];

  always #5 clock = ~clock;

  router_pkt_tx #(.BUSY_TIMEOUT(4)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .i_cmd_valid   (i_cmd_valid),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_len     (i_cmd_len),
    .i_cmd_corrupt (i_cmd_corrupt),
    .o_cmd_ready   (o_cmd_ready),
    .i_pl_valid    (i_pl_valid),
    .i_pl_data     (i_pl_data),
    .o_pl_ready    (o_pl_ready),
    .i_busy        (i_busy),
    .o_pkt_valid   (o_pkt_valid),
    .o_data_out    (o_data_out),
    .o_done        (o_done),
    .o_err_cmd     (o_err_cmd),
    .o_err_timeout (o_err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, o_cmd_ready,   1'b1);
    check({tag, "_pl_ready"},  o_pl_ready,    1'b0);
    check({tag, "_pkt_valid"}, o_pkt_valid,   1'b0);
    check({tag, "_data_out"},  o_data_out,    8'h00);
    check({tag, "_done"},      o_done,        1'b0);
    check({tag, "_err_cmd"},   o_err_cmd,     1'b0);
    check({tag, "_err_to"},    o_err_timeout, 1'b0);
  endtask

  task automatic send_cmd(input logic [1:0] addr, input logic [5:0] len, input logic corrupt);
    i_cmd_valid   = 1'b1;
    i_cmd_addr    = addr;
    i_cmd_len     = len;
    i_cmd_corrupt = corrupt;
    tick();
    i_cmd_valid   = 1'b0;
  endtask

  task automatic fill(input int len);
    for (int i = 0; i < len; i++) begin
      i_pl_valid = 1'b1;
      i_pl_data  = pl_buf[i];
      tick();
    end
    i_pl_valid = 1'b0;
  endtask

  // Starts in the cycle the header is on the bus; ends in the done cycle.
  // 'hold' busy edges are inserted while the first payload byte is shown.
  task automatic xmit(input string tag, input int len, input logic [7:0] exp_hdr,
                      input logic [7:0] exp_par, input int hold);
    logic [7:0] exp_b;
    for (int k = 0; k <= len + 1; k++) begin
      if (k == 0)        exp_b = exp_hdr;
      else if (k <= len) exp_b = pl_buf[k-1];
      else               exp_b = exp_par;
      check($sformatf("%s_vld%0d", tag, k),  o_pkt_valid, (k <= len));
      check($sformatf("%s_data%0d", tag, k), o_data_out,  exp_b);
      if (k == 1 && hold > 0) begin
        i_busy = 1'b1;
        for (int h = 0; h < hold; h++) begin
          tick();
          check($sformatf("%s_hold_vld%0d", tag, h),  o_pkt_valid, 1'b1);
          check($sformatf("%s_hold_data%0d", tag, h), o_data_out,  exp_b);
        end
        i_busy = 1'b0;
      end
      tick();
    end
    check({tag, "_done"},      o_done,        1'b1);
    check({tag, "_cmd_ready"}, o_cmd_ready,   1'b1);
    check({tag, "_pkt_valid"}, o_pkt_valid,   1'b0);
    check({tag, "_err_to"},    o_err_timeout, 1'b0);
  endtask

  initial begin
    logic [7:0] par;

    resetn = 1'b0; i_cmd_valid = 1'b0; i_cmd_addr = '0; i_cmd_len = '0;
    i_cmd_corrupt = 1'b0; i_pl_valid = 1'b0; i_pl_data = '0; i_busy = 1'b0;
    tick();
    tick();
    check_reset_outputs("rst");
    resetn = 1'b1;

    // Basic packet: addr 1, len 3 -> header 0D, parity 0D.
    pl_buf[0] = 8'h11; pl_buf[1] = 8'h22; pl_buf[2] = 8'h33;
    send_cmd(2'd1, 6'd3, 1'b0);
    check("t1_cmd_ready", o_cmd_ready, 1'b0);
    check("t1_pl_ready",  o_pl_ready,  1'b1);
    fill(3);
    check("t1_pl_ready_off", o_pl_ready, 1'b0);
    xmit("t1", 3, 8'h0D, 8'h0D, 0);

    // Back-to-back command in the done cycle; busy stalls byte 11 twice.
    send_cmd(2'd1, 6'd3, 1'b0);
    check("t2_done_clr", o_done,     1'b0);
    check("t2_pl_ready", o_pl_ready, 1'b1);
    fill(3);
    xmit("t2", 3, 8'h0D, 8'h0D, 2);
    tick();
    check("t2_done_pulse", o_done, 1'b0);

    // Illegal commands.
    send_cmd(2'd3, 6'd5, 1'b0);
    check("t3a_err_cmd",   o_err_cmd,   1'b1);
    check("t3a_pl_ready",  o_pl_ready,  1'b0);
    check("t3a_cmd_ready", o_cmd_ready, 1'b1);
    tick();
    check("t3a_err_clr",   o_err_cmd,   1'b0);
    check("t3a_pl_ready2", o_pl_ready,  1'b0);
    send_cmd(2'd0, 6'd0, 1'b0);
    check("t3b_err_cmd",   o_err_cmd,   1'b1);
    check("t3b_pl_ready",  o_pl_ready,  1'b0);
    tick();
    check("t3b_err_clr",   o_err_cmd,   1'b0);

    // Corrupted parity: addr 2, len 1, AA -> 06, AA, 53.
    pl_buf[0] = 8'hAA;
    send_cmd(2'd2, 6'd1, 1'b1);
    fill(1);
    xmit("t4", 1, 8'h06, 8'h53, 0);
    tick();

    // Busy timeout in PAYLOAD (BUSY_TIMEOUT = 4).
    pl_buf[0] = 8'h01; pl_buf[1] = 8'h02;
    send_cmd(2'd0, 6'd2, 1'b0);
    fill(2);
    check("t5_hdr", o_data_out, 8'h08);
    tick();
    check("t5_b0", o_data_out, 8'h01);
    i_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t5_wait_to%0d", i),  o_err_timeout, 1'b0);
      check($sformatf("t5_wait_vld%0d", i), o_pkt_valid,   1'b1);
      check($sformatf("t5_wait_dat%0d", i), o_data_out,    8'h01);
    end
    tick();
    check("t5_err_to",    o_err_timeout, 1'b1);
    check("t5_pkt_valid", o_pkt_valid,   1'b0);
    check("t5_data_out",  o_data_out,    8'h00);
    check("t5_cmd_ready", o_cmd_ready,   1'b1);
    i_busy = 1'b0;
    tick();
    check("t5_err_clr",   o_err_timeout, 1'b0);

    // Reset mid-PAYLOAD, then a full-length packet.
    pl_buf[0] = 8'h11; pl_buf[1] = 8'h22; pl_buf[2] = 8'h33;
    send_cmd(2'd1, 6'd3, 1'b0);
    fill(3);
    tick();
    tick();
    check("t6_mid_data", o_data_out,  8'h22);
    check("t6_mid_vld",  o_pkt_valid, 1'b1);
    resetn = 1'b0;
    tick();
    check_reset_outputs("t6_rst");
    resetn = 1'b1;
    par = 8'hFE;
    for (int i = 0; i < 63; i++) begin
      pl_buf[i] = 8'((i * 7) + 3);
      par = par ^ pl_buf[i];
    end
    send_cmd(2'd2, 6'd63, 1'b0);
    fill(63);
    xmit("t6", 63, 8'hFE, par, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet source for the 1x3 router input port. Accepts a command (destination address, payload length) plus its payload bytes into a local buffer, then drives the router's `pkt_valid`/`data_in` interface: header, payload, parity. It honours the router's `busy` back-pressure and aborts on a busy timeout. It sits upstream of the router in test harnesses and SoC integration, as the transmit end of the same link the router FSM receives.

## Interface
- `BUSY_TIMEOUT`, 64: consecutive busy-high cycles during transmission before abort (≥2).
- `clock`  in  1  rising-edge clock.
- `resetn`  in  1  reset: synchronous, active-low.
- `cmd_valid`  in  1  command request.
- `cmd_addr`  in  2  destination port, 0..2 legal.
- `cmd_len`  in  6  payload byte count, 1..63 legal.
- `cmd_corrupt`  in  1  when set, the transmitted parity is inverted (error injection).
- `cmd_ready`  out  1  high only in IDLE.
- `pl_valid`  in  1  payload byte valid.
- `pl_data`  in  8  payload byte.
- `pl_ready`  out  1  high only in FILL.
- `busy`  in  1  router back-pressure.
- `pkt_valid`  out  1  to router `pkt_valid`.
- `data_out`  out  8  to router `data_in`.
- `done`  out  1  one-cycle pulse: parity byte accepted.
- `err_cmd`  out  1  one-cycle pulse: illegal command rejected.
- `err_timeout`  out  1  one-cycle pulse: packet aborted on timeout.

## Operation
- States: IDLE, FILL, HEADER, PAYLOAD, PARITY.
- IDLE: command handshake is `cmd_valid && cmd_ready`.
  - Legal command: latch addr, len and corrupt; clear the write pointer; go to FILL.
  - `cmd_addr==3` or `cmd_len==0`: pulse `err_cmd`, stay in IDLE.
- FILL: each `pl_valid && pl_ready` writes `pl_data` to `buf[wptr]` and increments `wptr`. When the write of byte index len-1 completes, go to HEADER. No timeout applies in FILL.
- HEADER: `pkt_valid=1`, `data_out={len,addr}`.
- "Accepted" means a rising edge with `busy==0` in HEADER, PAYLOAD or PARITY.
- Header accepted: parity accumulator is set to the header byte; go to PAYLOAD with `rptr=0`.
- PAYLOAD: `pkt_valid=1`, `data_out=buf[rptr]`.
  - Each accept XORs the byte into parity and increments `rptr`.
  - Accepting byte len-1 moves to PARITY.
- PARITY: `pkt_valid=0`, `data_out=parity ^ {8{corrupt}}`. On accept, pulse `done` and go to IDLE.
- Busy timeout counter: clears on every accept and on entry to HEADER; increments each cycle `busy==1` in HEADER/PAYLOAD/PARITY.
  - When it reaches BUSY_TIMEOUT: pulse `err_timeout`, `pkt_valid=0`, `data_out=0`, go to IDLE.
- `cmd_*` and `pl_*` are ignored outside IDLE and FILL respectively.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `cmd_ready=1`, `pl_ready=0`, `pkt_valid=0`, `data_out=8'h00`, `done=err_cmd=err_timeout=0`, pointers, parity and counter at 0.
- Reset mid-packet: `pkt_valid` drops on the reset edge; the buffer contents are don't-care.
- Latency:
  - Command accept to first `pl_ready`: 1 cycle.
  - Last payload write to header on the bus: 1 cycle.
  - Each accept to next byte on `data_out`: 1 cycle.
  - With `busy` low throughout, one packet occupies len+2 bus cycles.
- While `busy==1`, `pkt_valid` and `data_out` hold stable.
- After an accept, the next byte is presented even if `busy` rises that cycle. This matches the router raising busy in its first-data state while the first payload byte is held.
- `done` and `err_timeout` are asserted in the same cycle as the return to IDLE. `cmd_ready` is high again in that same cycle; a back-to-back command is accepted on the next edge.
- Timeout fires on the edge at which the count reaches BUSY_TIMEOUT, i.e. after exactly BUSY_TIMEOUT consecutive busy-high edges.

## Structure
- Package `router_pkg`:
  - state enum;
  - `ADDR_INVALID=2'b11`, `LEN_MAX=6'd63`;
  - header pack function `{len,addr}`.
- Sub-module `router_tx_buf`: 64x8 register buffer, one synchronous write port and one read port. The read address is driven by the next-`rptr` value so that `data_out` stays registered.
- Top: FSM, pointers, parity accumulator and timeout counter; roughly 200 RTL lines.

## Test plan
- addr=1, len=3, payload 11,22,33, busy=0 → bus shows 0D,11,22,33,then parity 0D^11^22^33=0D with `pkt_valid=0`; `done` pulses; 5 bus cycles from header.
- Same packet with busy=1 for 2 cycles right after the header accept → byte 11 is held for 3 cycles, then the sequence continues; the parity value is unchanged.
- addr=3 or len=0 → `err_cmd` one pulse, `pl_ready` stays 0, FSM stays in IDLE.
- `cmd_corrupt=1`, addr=2, len=1, payload AA → bus shows 06, AA, then parity 53.
- BUSY_TIMEOUT=4, busy held high in PAYLOAD → `err_timeout` pulses on the 4th busy edge; `pkt_valid=0`, `data_out=00`, `cmd_ready=1`.
- `resetn` low for one edge in mid-PAYLOAD → all outputs return to their reset values the next cycle; a following len=63 packet completes with correct parity.
